// File: rtl/dct_row_butterfly.sv
// Row DCT front end: collects 8 pixels, level-shifts them, forms the even/odd butterfly,
// and launches the DA stages no more often than once every DA_GAP cycles.
module dct_row_butterfly #(
  parameter int DA_GAP = 6
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               pix_valid,
  input  logic [7:0]         pix_data,
  output logic               pix_ready,
  output logic signed [11:0] X0,
  output logic signed [11:0] X1,
  output logic signed [11:0] X2,
  output logic signed [11:0] X3,
  output logic signed [11:0] D0,
  output logic signed [11:0] D1,
  output logic signed [11:0] D2,
  output logic signed [11:0] D3,
  output logic               DA_start,
  output logic [2:0]         row_idx,
  output logic               blk_done
);

  // state   | meaning
  // COLLECT | accepting pixels; launches directly on the 8th if the gap allows
  // PEND    | full row held, waiting for the DA gap before launching
  typedef enum logic {ST_COLLECT, ST_PEND} state_t;

  localparam logic [3:0] GAP_MIN = 4'(DA_GAP - 1);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_col;
  logic signed [8:0] r_s [7];
  logic signed [8:0] r_s7;
  logic [3:0]        r_gap;
  logic [2:0]        r_row_nxt;
  logic [2:0]        r_row_idx;
  logic signed [11:0] r_x [4];
  logic signed [11:0] r_d [4];
  logic              r_da_start;
  logic              r_blk_done;

  logic              w_xfer;
  logic              w_last;
  logic              w_gap_ok;
  logic              w_launch;
  logic signed [8:0] w_s_in;
  logic signed [8:0] w_smp [8];

  assign w_s_in   = $signed({1'b0, pix_data} - 9'd128);
  assign w_last   = (r_col == 3'd7);
  assign w_gap_ok = (r_gap >= GAP_MIN);
  assign w_xfer   = pix_valid & pix_ready;

  // In COLLECT the 8th sample comes straight from the input; in PEND from the holding register.
  always_comb begin
    for (int k = 0; k < 7; k++) w_smp[k] = r_s[k];
    w_smp[7] = (r_state == ST_COLLECT) ? w_s_in : r_s7;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_COLLECT;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (w_xfer && w_last && !w_gap_ok) w_state_nxt = ST_PEND;
      ST_PEND:    if (w_gap_ok) w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    w_launch  = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        pix_ready = 1'b1;
        w_launch  = pix_valid && w_last && w_gap_ok;
      end
      ST_PEND:    w_launch = w_gap_ok;
      default:    w_launch = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_col      <= '0;
      for (int k = 0; k < 7; k++) r_s[k] <= '0;
      r_s7       <= '0;
      r_gap      <= 4'hF;
      r_row_nxt  <= '0;
      r_row_idx  <= '0;
      for (int k = 0; k < 4; k++) begin
        r_x[k] <= '0;
        r_d[k] <= '0;
      end
      r_da_start <= 1'b0;
      r_blk_done <= 1'b0;
    end else begin
      r_da_start <= w_launch;
      r_blk_done <= w_launch && (r_row_nxt == 3'd7);
      if (w_xfer) begin
        r_col <= r_col + 3'd1;
        if (!w_last) r_s[r_col] <= w_s_in;
        else         r_s7 <= w_s_in;
      end
      if (w_launch)           r_gap <= '0;
      else if (r_gap != 4'hF) r_gap <= r_gap + 4'd1;
      if (w_launch) begin
        for (int k = 0; k < 4; k++) begin
          r_x[k] <= {{3{w_smp[k][8]}}, w_smp[k]} + {{3{w_smp[7-k][8]}}, w_smp[7-k]};
          r_d[k] <= {{3{w_smp[k][8]}}, w_smp[k]} - {{3{w_smp[7-k][8]}}, w_smp[7-k]};
        end
        r_row_idx <= r_row_nxt;
        r_row_nxt <= r_row_nxt + 3'd1;
      end
    end
  end

  assign X0       = r_x[0];
  assign X1       = r_x[1];
  assign X2       = r_x[2];
  assign X3       = r_x[3];
  assign D0       = r_d[0];
  assign D1       = r_d[1];
  assign D2       = r_d[2];
  assign D3       = r_d[3];
  assign DA_start = r_da_start;
  assign row_idx  = r_row_idx;
  assign blk_done = r_blk_done;

endmodule

// File: tb/tb_dct_row_butterfly.sv
// Bench for dct_row_butterfly: table of directed rows on a DA_GAP=6 instance,
// plus continuous-stream, mid-row reset and DA_GAP=10 throttling sequences.
module tb_dct_row_butterfly;

  typedef logic [7:0] row_t [8];
  typedef int quad_t [4];
  typedef struct {
    row_t  pix;
    quad_t x;
    quad_t d;
  } vec_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic               a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0]         a_data = '0, b_data = '0;
  logic               a_ready, b_ready, a_da, b_da, a_blk, b_blk;
  logic [2:0]         a_row, b_row;
  logic signed [11:0] a_x [4], a_d [4], b_x [4], b_d [4];

  dct_row_butterfly #(.DA_GAP(6)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_valid(a_valid), .pix_data(a_data),
    .pix_ready(a_ready),
    .X0(a_x[0]), .X1(a_x[1]), .X2(a_x[2]), .X3(a_x[3]),
    .D0(a_d[0]), .D1(a_d[1]), .D2(a_d[2]), .D3(a_d[3]),
    .DA_start(a_da), .row_idx(a_row), .blk_done(a_blk)
  );

  dct_row_butterfly #(.DA_GAP(10)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_valid(b_valid), .pix_data(b_data),
    .pix_ready(b_ready),
    .X0(b_x[0]), .X1(b_x[1]), .X2(b_x[2]), .X3(b_x[3]),
    .D0(b_d[0]), .D1(b_d[1]), .D2(b_d[2]), .D3(b_d[3]),
    .DA_start(b_da), .row_idx(b_row), .blk_done(b_blk)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic void model(input row_t p, output quad_t x, output quad_t d);
    for (int k = 0; k < 4; k++) begin
      x[k] = (int'(p[k]) - 128) + (int'(p[7-k]) - 128);
      d[k] = (int'(p[k]) - 128) - (int'(p[7-k]) - 128);
    end
  endfunction

  int exp_row_a = 0;

  task automatic check_launch_a(input string tg, input quad_t ex, input quad_t ed);
    chk({tg, "_start"}, int'(a_da), 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_X%0d", tg, k), int'(a_x[k]), ex[k]);
      chk($sformatf("%s_D%0d", tg, k), int'(a_d[k]), ed[k]);
    end
    chk({tg, "_row_idx"}, int'(a_row), exp_row_a);
    chk({tg, "_blk_done"}, int'(a_blk), (exp_row_a == 7) ? 1 : 0);
    exp_row_a = (exp_row_a + 1) % 8;
  endtask

  // Sends one row to instance A; optionally drops pix_valid for hold_cycles before pixel hold_after.
  task automatic send_row_a(input string tg, input row_t p, input int hold_after, input int hold_cycles);
    int early = 0;
    int notready = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == hold_after) begin
        a_valid = 1'b0;
        repeat (hold_cycles) begin
          @(posedge sys_clk); #1;
          if (a_da) early++;
        end
      end
      a_valid = 1'b1;
      a_data  = p[i];
      if (!a_ready) notready++;
      @(posedge sys_clk); #1;
      if (i < 7 && a_da) early++;
    end
    a_valid = 1'b0;
    chk({tg, "_early_start"}, early, 0);
    chk({tg, "_ready_drop"}, notready, 0);
  endtask

  vec_t  vecs [6];
  row_t  rb;
  quad_t ex, ed;
  logic [7:0] bp [32];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0].pix = '{default: 8'd128};
    vecs[0].x   = '{0, 0, 0, 0};
    vecs[0].d   = '{0, 0, 0, 0};
    vecs[1].pix = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    vecs[1].x   = '{-166, -166, -166, -166};
    vecs[1].d   = '{-70, -50, -30, -10};
    vecs[2].pix = '{default: 8'd255};
    vecs[2].x   = '{254, 254, 254, 254};
    vecs[2].d   = '{0, 0, 0, 0};
    vecs[3].pix = '{default: 8'd0};
    vecs[3].x   = '{-256, -256, -256, -256};
    vecs[3].d   = '{0, 0, 0, 0};
    vecs[4].pix = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255};
    vecs[4].x   = '{254, -256, 254, -256};
    vecs[4].d   = '{0, 0, 0, 0};
    vecs[5].pix = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255};
    vecs[5].x   = '{254, -1, -1, -256};
    vecs[5].d   = '{0, 255, -255, 0};

    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    chk("rst_ready_a", int'(a_ready), 1);
    chk("rst_ready_b", int'(b_ready), 1);
    chk("rst_start_a", int'(a_da), 0);
    chk("rst_blk_a", int'(a_blk), 0);
    chk("rst_row_a", int'(a_row), 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_X%0d", k), int'(a_x[k]), 0);
      chk($sformatf("rst_D%0d", k), int'(a_d[k]), 0);
    end

    // Directed table, rows back to back
    for (int v = 0; v < 6; v++) begin
      send_row_a($sformatf("vec%0d", v), vecs[v].pix, 8, 0);
      check_launch_a($sformatf("vec%0d", v), vecs[v].x, vecs[v].d);
      if (v == 1) begin
        repeat (5) @(posedge sys_clk);
        #1;
        chk("hold_start", int'(a_da), 0);
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("hold_X%0d", k), int'(a_x[k]), vecs[1].x[k]);
          chk($sformatf("hold_D%0d", k), int'(a_d[k]), vecs[1].d[k]);
        end
        chk("hold_row", int'(a_row), 1);
      end
    end

    // pix_valid low in the middle of a row
    rb = '{8'd3, 8'd200, 8'd77, 8'd128, 8'd9, 8'd250, 8'd140, 8'd61};
    model(rb, ex, ed);
    send_row_a("midgap", rb, 4, 7);
    check_launch_a("midgap", ex, ed);

    // 64 continuous pixels on DA_GAP=6: launch every 8 cycles, never throttled
    @(posedge sys_clk); #1 sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    exp_row_a = 0;
    begin
      int last = 0;
      int notready = 0;
      int spurious = 0;
      for (int i = 0; i < 64; i++) begin
        rb[i % 8] = 8'($urandom);
        a_valid = 1'b1;
        a_data  = rb[i % 8];
        if (!a_ready) notready++;
        @(posedge sys_clk); #1;
        if (i % 8 == 7) begin
          model(rb, ex, ed);
          check_launch_a($sformatf("cont_r%0d", i / 8), ex, ed);
          if (i > 7) chk($sformatf("cont_space%0d", i / 8), cyc - last, 8);
          last = cyc;
        end else if (a_da || a_blk) begin
          spurious++;
        end
      end
      a_valid = 1'b0;
      chk("cont_ready_drop", notready, 0);
      chk("cont_spurious", spurious, 0);
    end

    // Reset after 5 pixels of a row; the partial row must vanish
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1;
      a_data  = 8'd17;
      @(posedge sys_clk); #1;
    end
    a_valid = 1'b0;
    sys_rst_n = 1'b0;
    #2;
    chk("midrst_row", int'(a_row), 0);
    chk("midrst_start", int'(a_da), 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    exp_row_a = 0;
    rb = '{8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150, 8'd160, 8'd170};
    model(rb, ex, ed);
    send_row_a("midrst", rb, 8, 0);
    check_launch_a("midrst", ex, ed);

    // DA_GAP=10 with continuous source: 2 stall cycles per row after the first
    for (int i = 0; i < 32; i++) bp[i] = 8'($urandom);
    begin
      int idx = 0;
      int ns = 0;
      int rl = 0;
      int last = 0;
      logic took;
      b_valid = 1'b1;
      b_data  = bp[0];
      for (int c = 0; c < 200 && ns < 4; c++) begin
        took = b_valid && b_ready;
        if (!b_ready) rl++;
        @(posedge sys_clk); #1;
        if (took) idx++;
        if (b_da) begin
          for (int k = 0; k < 8; k++) rb[k] = bp[ns*8 + k];
          model(rb, ex, ed);
          for (int k = 0; k < 4; k++) begin
            chk($sformatf("gap10_r%0d_X%0d", ns, k), int'(b_x[k]), ex[k]);
            chk($sformatf("gap10_r%0d_D%0d", ns, k), int'(b_d[k]), ed[k]);
          end
          chk($sformatf("gap10_r%0d_row", ns), int'(b_row), ns);
          if (ns > 0) chk($sformatf("gap10_space%0d", ns), cyc - last, 10);
          last = cyc;
          ns++;
        end
        if (idx < 32) b_data = bp[idx];
        else          b_valid = 1'b0;
      end
      b_valid = 1'b0;
      chk("gap10_rows", ns, 4);
      chk("gap10_ready_low", rl, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
